// File: rtl/traffic_light.sv
// Single-road traffic-light sequencer: RED -> GREEN -> YELLOW -> RED, each phase
// held for a parameterised number of clock cycles.

package traffic_light_pkg;
  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } state_t;
endpackage

// Elaboration-time guard: a phase of zero cycles cannot be sequenced.
module traffic_light_cfg_check #(
  parameter int RED_CYCLES    = 5,
  parameter int GREEN_CYCLES  = 5,
  parameter int YELLOW_CYCLES = 2
) ();
  if (RED_CYCLES < 1) begin : g_bad_red
    $error("traffic_light: RED_CYCLES must be >= 1");
  end
  if (GREEN_CYCLES < 1) begin : g_bad_green
    $error("traffic_light: GREEN_CYCLES must be >= 1");
  end
  if (YELLOW_CYCLES < 1) begin : g_bad_yellow
    $error("traffic_light: YELLOW_CYCLES must be >= 1");
  end
endmodule

module traffic_light #(
  parameter int RED_CYCLES    = 5,
  parameter int GREEN_CYCLES  = 5,
  parameter int YELLOW_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] light
);
  import traffic_light_pkg::*;

  localparam int MAX_RG  = (RED_CYCLES > GREEN_CYCLES) ? RED_CYCLES : GREEN_CYCLES;
  localparam int MAX_DUR = (MAX_RG > YELLOW_CYCLES) ? MAX_RG : YELLOW_CYCLES;
  localparam int CW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  // Terminal count of each phase; cnt_r reaching it ends the phase.
  localparam logic [CW-1:0] RED_LAST    = CW'(RED_CYCLES - 1);
  localparam logic [CW-1:0] GREEN_LAST  = CW'(GREEN_CYCLES - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO    = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1'b1);

  state_t        state_r;
  logic [CW-1:0] cnt_r;

  traffic_light_cfg_check #(
    .RED_CYCLES   (RED_CYCLES),
    .GREEN_CYCLES (GREEN_CYCLES),
    .YELLOW_CYCLES(YELLOW_CYCLES)
  ) u_cfg_check ();

  // Phase sequencer: count within a phase, advance and clear at terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RED;
      cnt_r   <= CNT_ZERO;
    end else begin
      case (state_r)
        RED: begin
          if (cnt_r == RED_LAST) begin
            state_r <= GREEN;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        GREEN: begin
          if (cnt_r == GREEN_LAST) begin
            state_r <= YELLOW;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        YELLOW: begin
          if (cnt_r == YELLOW_LAST) begin
            state_r <= RED;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= RED;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Lamp code decoded straight from the state register; any corrupt code reads as RED.
  always_comb begin
    light = 2'b00;
    case (state_r)
      RED:     light = 2'b00;
      GREEN:   light = 2'b01;
      YELLOW:  light = 2'b10;
      default: light = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_traffic_light.sv
// Directed bench for traffic_light: default and all-ones durations, async reset,
// long-run phase accounting and recovery from a corrupted state register.

module tb_traffic_light;
  logic       clk;
  logic       reset;
  logic [1:0] light_d;
  logic [1:0] light_m;
  int         n_cmp;
  int         n_err;
  int         c00, c01, c10, c11;

  traffic_light dut (
    .clk  (clk),
    .reset(reset),
    .light(light_d)
  );

  traffic_light #(
    .RED_CYCLES   (1),
    .GREEN_CYCLES (1),
    .YELLOW_CYCLES(1)
  ) dut_min (
    .clk  (clk),
    .reset(reset),
    .light(light_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic wait_until(input time t);
    if (t > $time) #(t - $time);
  endtask

  // Expected default-parameter light after n counted edges (period 12: 5 RED, 5 GREEN, 2 YELLOW).
  function automatic logic [1:0] exp_default(input int n);
    int p;
    p = n % 12;
    if (p < 5) return 2'b00;
    else if (p < 10) return 2'b01;
    else return 2'b10;
  endfunction

  initial begin
    logic [1:0] e;
    n_cmp = 0;
    n_err = 0;
    c00 = 0; c01 = 0; c10 = 0; c11 = 0;

    // Reset hold and default sequence; minimal-duration instance in parallel.
    reset = 1'b1;
    wait_until(1);   chk("rst_light_t1", {2'b00, light_d}, 4'h0);
    wait_until(7);   chk("rst_light_after_edge", {2'b00, light_d}, 4'h0);
    chk("rst_cnt", {1'b0, dut.cnt_r}, 4'h0);
    chk("rst_min_light", {2'b00, light_m}, 4'h0);
    wait_until(10);  reset = 1'b0;
    wait_until(12);  chk("min_red0", {2'b00, light_m}, 4'h0);
    wait_until(20);  chk("min_green", {2'b00, light_m}, 4'h1);
    chk("min_cnt", {3'b000, dut_min.cnt_r}, 4'h0);
    wait_until(30);  chk("min_yellow", {2'b00, light_m}, 4'h2);
    wait_until(40);  chk("min_red1", {2'b00, light_m}, 4'h0);
    chk("def_red_45", {2'b00, light_d}, 4'h0);
    wait_until(50);  chk("def_red_50", {2'b00, light_d}, 4'h0);
    chk("min_green1", {2'b00, light_m}, 4'h1);
    wait_until(60);  chk("def_green_60", {2'b00, light_d}, 4'h1);
    wait_until(100); chk("def_green_100", {2'b00, light_d}, 4'h1);
    wait_until(110); chk("def_yellow_110", {2'b00, light_d}, 4'h2);
    wait_until(120); chk("def_yellow_120", {2'b00, light_d}, 4'h2);
    wait_until(130); chk("def_red_130", {2'b00, light_d}, 4'h0);
    wait_until(170); chk("def_red_170", {2'b00, light_d}, 4'h0);
    wait_until(180); chk("def_green_180", {2'b00, light_d}, 4'h1);

    // Async reset mid-GREEN, replayed on a fresh timeline at base 1000.
    wait_until(1000); reset = 1'b1;
    wait_until(1010); reset = 1'b0;
    wait_until(1070); chk("mid_green_before", {2'b00, light_d}, 4'h1);
    wait_until(1072); reset = 1'b1;
    wait_until(1073); chk("async_rst_light", {2'b00, light_d}, 4'h0);
    chk("async_rst_cnt", {1'b0, dut.cnt_r}, 4'h0);
    wait_until(1078); reset = 1'b0;
    wait_until(1120); chk("post_rst_red_1120", {2'b00, light_d}, 4'h0);
    wait_until(1130); chk("post_rst_green_1130", {2'b00, light_d}, 4'h1);

    // Long run: per-cycle check plus per-period phase accounting.
    wait_until(2000); reset = 1'b1;
    wait_until(2010); reset = 1'b0;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge clk);
      #1;
      e = exp_default(n);
      chk("long_run", {2'b00, light_d}, {2'b00, e});
      if (n <= 996) begin
        case (light_d)
          2'b00:   c00++;
          2'b01:   c01++;
          2'b10:   c10++;
          default: c11++;
        endcase
      end
    end
    chk("long_cnt_red", c00[11:0] == 12'd415 ? 4'h1 : 4'h0, 4'h1);
    chk("long_cnt_green", c01[11:0] == 12'd415 ? 4'h1 : 4'h0, 4'h1);
    chk("long_cnt_yellow", c10[11:0] == 12'd166 ? 4'h1 : 4'h0, 4'h1);
    chk("long_cnt_11", c11[3:0], 4'h0);

    // Corrupt the state register and watch it recover to a full RED phase.
    @(negedge clk);
    force dut.state_r = traffic_light_pkg::state_t'(2'b11);
    #1;
    chk("illegal_light", {2'b00, light_d}, 4'h0);
    #1;
    release dut.state_r;
    @(posedge clk);
    #1;
    chk("recover_light", {2'b00, light_d}, 4'h0);
    chk("recover_state", {2'b00, dut.state_r}, 4'h0);
    chk("recover_cnt", {1'b0, dut.cnt_r}, 4'h0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk("recover_red_hold", {2'b00, light_d}, 4'h0);
      chk("recover_red_cnt", {1'b0, dut.cnt_r}, k[3:0]);
    end
    @(posedge clk);
    #1;
    chk("recover_green", {2'b00, light_d}, 4'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
